// File: rtl/ita_step_scheduler.sv
// Step sequencer for the ITA attention datapath: walks every head through
// Q, K, V, QK, AV, OW, issuing tile commands and draining completions per step.

package ita_step_pkg;
   typedef enum logic [2:0] {
      StepQ    = 3'd0,
      StepK    = 3'd1,
      StepV    = 3'd2,
      StepQK   = 3'd3,
      StepAV   = 3'd4,
      StepOW   = 3'd5,
      StepIdle = 3'd6
   } step_e;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned DefaultH        = 1;
   localparam int unsigned DefaultCntWidth = 32;
   localparam int unsigned DefaultNHeadsW  = (DefaultH + 1 > 1) ? $clog2(DefaultH + 1) : 1;

   typedef struct packed {
      logic                         start;
      logic [DefaultNHeadsW-1:0]    n_heads;
      logic [DefaultCntWidth-1:0]   lin_tiles;
      logic [DefaultCntWidth-1:0]   attn_tiles;
      logic [5:0][7:0]              eps_mult;
      logic [5:0][7:0]              right_shift;
      logic [5:0][7:0]              add;
   } ctrl_t;
endpackage

module ita_step_scheduler #(
   parameter int unsigned H              = 1,
   parameter int unsigned MaxOutstanding = 8,
   parameter int unsigned CntWidth       = 32,
   parameter type         ctrl_t         = ita_step_pkg::ctrl_t
) (
   input  logic                                    clk_i,
   input  logic                                    rst_ni,
   input  ctrl_t                                   ctrl_i,
   output logic                                    busy_o,
   output logic                                    done_o,
   output ita_step_pkg::step_e                     step_o,
   output logic [ita_step_pkg::idx_width(H)-1:0]   head_idx_o,
   output logic [CntWidth-1:0]                     tile_idx_o,
   output logic                                    tile_valid_o,
   input  logic                                    tile_ready_i,
   input  logic                                    tile_done_i,
   output logic [7:0]                              eps_mult_o,
   output logic [7:0]                              right_shift_o,
   output logic [7:0]                              add_o
);
   localparam int unsigned HeadW   = ita_step_pkg::idx_width(H);
   localparam int unsigned OutW    = $clog2(MaxOutstanding + 1);
   localparam int unsigned NHeadsW = $bits(ctrl_i.n_heads);

   ita_step_pkg::step_e  step_q, step_d;
   logic                 busy_q, done_q;
   logic [HeadW-1:0]     head_q, head_d;
   logic [CntWidth-1:0]  issued_q, issued_d;
   logic [OutW-1:0]      outst_q, outst_d;

   logic [NHeadsW-1:0]   n_heads_q;
   logic [CntWidth-1:0]  lin_q, attn_q;
   logic [5:0][7:0]      eps_cfg_q, rs_cfg_q, add_cfg_q;
   logic [7:0]           eps_q, rs_q, add_q;

   logic [CntWidth-1:0]  count;
   logic                 xfer, done_eff, step_end, last_head;
   logic [5:0][7:0]      eps_src, rs_src, add_src;
   logic [7:0]           eps_d, rs_d, add_d;

   always_comb begin
      count = (step_q == ita_step_pkg::StepQK || step_q == ita_step_pkg::StepAV) ? attn_q : lin_q;
      tile_valid_o = (step_q != ita_step_pkg::StepIdle) && (issued_q < count)
                     && (outst_q < OutW'(MaxOutstanding));
      xfer     = tile_valid_o && tile_ready_i;
      // A completion with nothing outstanding only counts when it pairs with a transfer.
      done_eff = tile_done_i && ((outst_q != '0) || xfer);
      issued_d = issued_q + CntWidth'(xfer);
      outst_d  = outst_q + OutW'(xfer) - OutW'(done_eff);
      step_end = (step_q != ita_step_pkg::StepIdle) && (issued_d == count) && (outst_d == '0);
      last_head = (32'(head_q) + 32'd1) >= 32'(n_heads_q);
   end

   always_comb begin
      step_d = step_q;
      head_d = head_q;
      if (!busy_q) begin
         if (ctrl_i.start) begin
            step_d = (ctrl_i.n_heads == '0) ? ita_step_pkg::StepIdle : ita_step_pkg::StepQ;
            head_d = '0;
         end
      end else if (step_end) begin
         if (step_q == ita_step_pkg::StepOW) begin
            if (last_head) begin
               step_d = ita_step_pkg::StepIdle;
            end else begin
               step_d = ita_step_pkg::StepQ;
               head_d = head_q + 1'b1;
            end
         end else begin
            step_d = ita_step_pkg::step_e'(step_q + 3'd1);
         end
      end
   end

   // Requant values follow the next step so they register alongside step_q.
   always_comb begin
      eps_src = busy_q ? eps_cfg_q : ctrl_i.eps_mult;
      rs_src  = busy_q ? rs_cfg_q  : ctrl_i.right_shift;
      add_src = busy_q ? add_cfg_q : ctrl_i.add;
      eps_d   = '0;
      rs_d    = '0;
      add_d   = '0;
      if (step_d != ita_step_pkg::StepIdle) begin
         eps_d = eps_src[step_d];
         rs_d  = rs_src[step_d];
         add_d = add_src[step_d];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         step_q    <= ita_step_pkg::StepIdle;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         head_q    <= '0;
         issued_q  <= '0;
         outst_q   <= '0;
         n_heads_q <= '0;
         lin_q     <= '0;
         attn_q    <= '0;
         eps_cfg_q <= '0;
         rs_cfg_q  <= '0;
         add_cfg_q <= '0;
         eps_q     <= '0;
         rs_q      <= '0;
         add_q     <= '0;
      end else begin
         step_q <= step_d;
         head_q <= head_d;
         eps_q  <= eps_d;
         rs_q   <= rs_d;
         add_q  <= add_d;
         if (!busy_q) begin
            done_q <= 1'b0;
            if (ctrl_i.start) begin
               busy_q    <= 1'b1;
               done_q    <= (ctrl_i.n_heads == '0);
               n_heads_q <= ctrl_i.n_heads;
               lin_q     <= ctrl_i.lin_tiles;
               attn_q    <= ctrl_i.attn_tiles;
               eps_cfg_q <= ctrl_i.eps_mult;
               rs_cfg_q  <= ctrl_i.right_shift;
               add_cfg_q <= ctrl_i.add;
               issued_q  <= '0;
               outst_q   <= '0;
            end
         end else if (done_q) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
         end else if (step_end) begin
            issued_q <= '0;
            outst_q  <= '0;
            done_q   <= (step_q == ita_step_pkg::StepOW) && last_head;
         end else begin
            issued_q <= issued_d;
            outst_q  <= outst_d;
         end
      end
   end

   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign step_o        = step_q;
   assign head_idx_o    = head_q;
   assign tile_idx_o    = issued_q;
   assign eps_mult_o    = eps_q;
   assign right_shift_o = rs_q;
   assign add_o         = add_q;

endmodule

// File: tb/tb_ita_step_scheduler.sv
// Scoreboard bench for ita_step_scheduler: expected tile transfers, step
// sequence and done pulses are queued by the stimulus and checked by a monitor.

module tb_ita_step_scheduler;
   import ita_step_pkg::*;

   localparam int unsigned H  = 2;
   localparam int unsigned CW = 32;

   typedef struct packed {
      logic            start;
      logic [1:0]      n_heads;
      logic [CW-1:0]   lin_tiles;
      logic [CW-1:0]   attn_tiles;
      logic [5:0][7:0] eps_mult;
      logic [5:0][7:0] right_shift;
      logic [5:0][7:0] add;
   } tb_ctrl_t;

   typedef struct {
      logic [2:0]  step;
      int unsigned head;
      int unsigned tile;
   } xfer_t;

   typedef struct {
      logic [2:0]  step;
      int unsigned dur;
   } stp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   tb_ctrl_t      ctrl;
   logic          busy_o, done_o, tile_valid_o;
   step_e         step_o;
   logic [0:0]    head_idx_o;
   logic [CW-1:0] tile_idx_o;
   logic          tile_ready_i, tile_done_i;
   logic [7:0]    eps_mult_o, right_shift_o, add_o;

   ita_step_scheduler #(
      .H(H), .MaxOutstanding(8), .CntWidth(CW), .ctrl_t(tb_ctrl_t)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .ctrl_i(ctrl),
      .busy_o(busy_o), .done_o(done_o), .step_o(step_o),
      .head_idx_o(head_idx_o), .tile_idx_o(tile_idx_o),
      .tile_valid_o(tile_valid_o), .tile_ready_i(tile_ready_i),
      .tile_done_i(tile_done_i),
      .eps_mult_o(eps_mult_o), .right_shift_o(right_shift_o), .add_o(add_o)
   );

   always #5 clk = ~clk;

   int unsigned n_chk = 0, n_pass = 0;
   xfer_t xq[$];
   stp_t  sq[$];
   int unsigned dq = 0;
   int unsigned xfer_seen = 0;
   logic mon_on = 1'b0;
   logic auto_en = 1'b1;
   logic [1:0] pipe = 2'b00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic plan_head(input int unsigned head, input int unsigned lin, input int unsigned attn,
                            input int unsigned dl, input int unsigned da,
                            input int unsigned nsteps, input int unsigned nxsteps);
      for (int unsigned s = 0; s < nsteps; s++) begin
         stp_t e;
         e.step = 3'(s);
         e.dur  = (s == 3 || s == 4) ? da : dl;
         sq.push_back(e);
      end
      for (int unsigned s = 0; s < nxsteps; s++) begin
         int unsigned n;
         n = (s == 3 || s == 4) ? attn : lin;
         for (int unsigned t = 0; t < n; t++) begin
            xfer_t x;
            x.step = 3'(s);
            x.head = head;
            x.tile = t;
            xq.push_back(x);
         end
      end
   endtask

   task automatic push_idle();
      stp_t e;
      e.step = 3'(StepIdle);
      e.dur  = 0;
      sq.push_back(e);
   endtask

   task automatic plan_run(input int unsigned nh, input int unsigned lin, input int unsigned attn,
                           input int unsigned dl, input int unsigned da);
      for (int unsigned h = 0; h < nh; h++) plan_head(h, lin, attn, dl, da, 6, 6);
      if (nh > 0) push_idle();
      dq++;
   endtask

   task automatic start_run(input int unsigned nh, input int unsigned lin, input int unsigned attn);
      @(posedge clk); #1;
      ctrl.start      = 1'b1;
      ctrl.n_heads    = 2'(nh);
      ctrl.lin_tiles  = CW'(lin);
      ctrl.attn_tiles = CW'(attn);
      @(posedge clk); #1;
      ctrl.start = 1'b0;
   endtask

   task automatic wait_idle(input int unsigned budget);
      for (int unsigned i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!busy_o) break;
      end
      chk("idle_timeout", 32'(busy_o), 32'd0);
      chk("done_low_after", 32'(done_o), 32'd0);
   endtask

   // Datapath model: completes each transferred tile two cycles later.
   initial begin
      forever begin
         @(negedge clk);
         pipe = auto_en ? {pipe[0], tile_valid_o && tile_ready_i} : 2'b00;
         @(posedge clk); #1;
         if (auto_en) tile_done_i = pipe[1];
      end
   end

   // Monitor
   initial begin
      step_e prev_step;
      int unsigned cur_dur, dur_cnt;
      prev_step = StepIdle;
      cur_dur = 0;
      dur_cnt = 0;
      forever begin
         @(negedge clk);
         if (mon_on) begin
            if (tile_valid_o && tile_ready_i) begin
               xfer_seen++;
               if (xq.size() == 0) chk("xfer_unexpected", 32'(xq.size()), 32'd1);
               else begin
                  xfer_t e;
                  e = xq.pop_front();
                  chk("xfer_step", 32'(step_o), 32'(e.step));
                  chk("xfer_head", 32'(head_idx_o), e.head);
                  chk("xfer_tile", tile_idx_o, e.tile);
                  chk("xfer_eps", 32'(eps_mult_o), 32'h10 + 32'(e.step));
                  chk("xfer_rshift", 32'(right_shift_o), 32'h20 + 32'(e.step));
                  chk("xfer_add", 32'(add_o), 32'h30 + 32'(e.step));
               end
            end
            if (step_o !== prev_step) begin
               if (cur_dur != 0) chk("step_dur", dur_cnt, cur_dur);
               if (sq.size() == 0) begin
                  chk("step_unexpected", 32'(sq.size()), 32'd1);
                  cur_dur = 0;
               end else begin
                  stp_t s;
                  s = sq.pop_front();
                  chk("step_order", 32'(step_o), 32'(s.step));
                  cur_dur = s.dur;
               end
               dur_cnt = 1;
               prev_step = step_o;
            end else begin
               dur_cnt++;
            end
            if (done_o) begin
               if (dq == 0) chk("done_unexpected", dq, 32'd1);
               else begin
                  dq--;
                  chk("done_busy", 32'(busy_o), 32'd1);
                  chk("done_step", 32'(step_o), 32'(StepIdle));
                  chk("done_valid", 32'(tile_valid_o), 32'd0);
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int unsigned base;
      logic found;
      rst_n = 1'b0;
      ctrl = '0;
      for (int s = 0; s < 6; s++) begin
         ctrl.eps_mult[s]    = 8'h10 + 8'(s);
         ctrl.right_shift[s] = 8'h20 + 8'(s);
         ctrl.add[s]         = 8'h30 + 8'(s);
      end
      tile_ready_i = 1'b0;
      tile_done_i  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_step", 32'(step_o), 32'(StepIdle));
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_valid", 32'(tile_valid_o), 32'd0);
      chk("rst_head", 32'(head_idx_o), 32'd0);
      chk("rst_tile", tile_idx_o, 32'd0);
      chk("rst_requant", {8'd0, eps_mult_o, right_shift_o, add_o}, 32'd0);
      rst_n  = 1'b1;
      mon_on = 1'b1;

      // 1) basic run, one head
      tile_ready_i = 1'b1;
      base = xfer_seen;
      plan_run(1, 2, 3, 4, 5);
      start_run(1, 2, 3);
      wait_idle(300);
      chk("t1_tiles", xfer_seen - base, 32'd14);

      // 2) zero heads
      plan_run(0, 1, 1, 0, 0);
      start_run(0, 1, 1);
      chk("t2_done", 32'(done_o), 32'd1);
      chk("t2_busy", 32'(busy_o), 32'd1);
      chk("t2_step", 32'(step_o), 32'(StepIdle));
      chk("t2_valid", 32'(tile_valid_o), 32'd0);
      @(posedge clk); #1;
      chk("t2_busy_after", 32'(busy_o), 32'd0);
      chk("t2_done_after", 32'(done_o), 32'd0);

      // 3) zero linear tiles
      plan_run(1, 0, 1, 1, 3);
      start_run(1, 0, 1);
      wait_idle(100);

      // 4) backpressure
      tile_ready_i = 1'b0;
      plan_run(1, 1, 0, 0, 1);
      start_run(1, 1, 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t4_valid_held", 32'(tile_valid_o), 32'd1);
         chk("t4_idx_stable", tile_idx_o, 32'd0);
         chk("t4_step", 32'(step_o), 32'(StepQ));
      end
      @(posedge clk); #1;
      tile_ready_i = 1'b1;
      wait_idle(100);

      // 5) outstanding limit
      @(negedge clk);
      auto_en = 1'b0;
      tile_done_i = 1'b0;
      begin
         stp_t e;
         e.step = 3'(StepQ);
         e.dur = 0;
         sq.push_back(e);
      end
      for (int unsigned t = 0; t < 9; t++) begin
         xfer_t x;
         x.step = 3'(StepQ);
         x.head = 0;
         x.tile = t;
         xq.push_back(x);
      end
      push_idle();
      start_run(1, 20, 0);
      repeat (12) @(negedge clk);
      chk("t5_valid_low", 32'(tile_valid_o), 32'd0);
      chk("t5_idx8", tile_idx_o, 32'd8);
      @(posedge clk); #1;
      tile_done_i = 1'b1;
      @(posedge clk); #1;
      tile_done_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("t5_valid_low2", 32'(tile_valid_o), 32'd0);
      chk("t5_idx9", tile_idx_o, 32'd9);
      chk("t5_xq_empty", 32'(xq.size()), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_step", 32'(step_o), 32'(StepIdle));
      chk("t5_rst_busy", 32'(busy_o), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      auto_en = 1'b1;

      // 6) reset during AV of head 1, restart, ignored start while busy
      plan_head(0, 1, 1, 3, 3, 6, 6);
      plan_head(1, 1, 1, 3, 0, 5, 5);
      push_idle();
      start_run(2, 1, 1);
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (step_o == StepAV && head_idx_o == 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      chk("t6_reach_av_h1", 32'(found), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_step", 32'(step_o), 32'(StepIdle));
      chk("t6_rst_busy", 32'(busy_o), 32'd0);
      chk("t6_rst_valid", 32'(tile_valid_o), 32'd0);
      chk("t6_rst_head", 32'(head_idx_o), 32'd0);
      chk("t6_rst_eps", 32'(eps_mult_o), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      plan_run(1, 1, 1, 3, 3);
      start_run(1, 1, 1);
      found = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (step_o == StepK) begin
            found = 1'b1;
            break;
         end
      end
      chk("t6_reach_k", 32'(found), 32'd1);
      @(posedge clk); #1;
      ctrl.start = 1'b1;
      ctrl.n_heads = 2'd2;
      ctrl.lin_tiles = CW'(3);
      @(posedge clk); #1;
      ctrl.start = 1'b0;
      wait_idle(200);

      repeat (4) @(negedge clk);
      chk("end_xq_empty", 32'(xq.size()), 32'd0);
      chk("end_sq_empty", 32'(sq.size()), 32'd0);
      chk("end_dq_empty", dq, 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
